core_run_controller: RTL

//  Run-control sequencer for the single-cycle RV32 core. Drives core_en: PC register, register-file write and

---
 rtl/core_dbg_pkg.sv | 12 +
 rtl/dbg_counter.sv | 15 +
 rtl/core_run_controller.sv | 106 ++++++++++
 3 files changed

// File: rtl/core_dbg_pkg.sv
// core_dbg_pkg: shared encodings for the core run controller
package core_dbg_pkg;
    typedef enum logic [1:0] {ST_HALTED = 2'd0, ST_RUN = 2'd1, ST_STEP = 2'd2} state_t;
    typedef enum logic [1:0] {OP_HALT = 2'd0, OP_RUN = 2'd1, OP_STEP = 2'd2, OP_SET_BP = 2'd3} cmd_op_t;
    typedef enum logic [1:0] {
        CAUSE_CMD        = 2'd0,
        CAUSE_STEP_DONE  = 2'd1,
        CAUSE_BREAKPOINT = 2'd2,
        CAUSE_EBREAK     = 2'd3
    } halt_cause_t;
    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;
endpackage

// File: rtl/dbg_counter.sv
// dbg_counter: wrapping event counter with synchronous active-low clear
module dbg_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);
    // clear on reset, otherwise count enabled cycles and wrap silently
    always_ff @(posedge clk) begin
        if (!reset) count <= '0;
        else if (en) count <= count + W'(1);
    end
endmodule

// File: rtl/core_run_controller.sv
// core_run_controller: run/halt/step/breakpoint sequencer gating the core datapath
module core_run_controller
    import core_dbg_pkg::*;
#(
    parameter bit RUN_ON_RESET = 1'b1,
    parameter int STEP_W       = 16,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    input  logic [31:0]      cmd_arg,
    input  logic [31:0]      PC,
    input  logic [31:0]      Instr,
    output logic             core_en,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic             cmd_err,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retired_count
);
    state_t            state, state_n;
    halt_cause_t       cause, cause_n;
    cmd_op_t           op;
    logic              bp_en, bp_en_n, skip, skip_n, cmd_err_n;
    logic [31:0]       bp_addr, bp_addr_n;
    logic [STEP_W-1:0] step_rem, step_rem_n, step_arg;
    logic              active, bp_hit, eb_hit, bp_set;
    logic              unused_arg;

    assign unused_arg = cmd_arg[1];
    assign halted     = state == ST_HALTED;
    assign halt_cause = cause;

    // hit detection, datapath enable and next-state selection; halts outrank commands
    always_comb begin
        op         = cmd_op_t'(cmd_op);
        active     = state != ST_HALTED;
        bp_hit     = bp_en && PC == bp_addr && !skip;
        eb_hit     = Instr == EBREAK_INSTR && !skip;
        core_en    = active && !bp_hit && !eb_hit && reset;
        step_arg   = cmd_arg[STEP_W-1:0];
        bp_set     = cmd_valid && op == OP_SET_BP;
        bp_addr_n  = bp_set ? {cmd_arg[31:2], 2'b00} : bp_addr;
        bp_en_n    = bp_set ? cmd_arg[0] : bp_en;
        cmd_err_n  = cmd_valid && (op == OP_RUN || op == OP_STEP) && active;
        state_n    = state;
        cause_n    = cause;
        skip_n     = core_en ? 1'b0 : skip;
        step_rem_n = (state == ST_STEP && core_en) ? step_rem - STEP_W'(1) : step_rem;
        if (active && (bp_hit || eb_hit)) begin
            state_n = ST_HALTED;
            cause_n = bp_hit ? CAUSE_BREAKPOINT : CAUSE_EBREAK;
        end else if (state == ST_STEP && core_en && step_rem == STEP_W'(1)) begin
            state_n = ST_HALTED;
            cause_n = CAUSE_STEP_DONE;
        end else if (cmd_valid && op == OP_HALT && active) begin
            state_n = ST_HALTED;
            cause_n = CAUSE_CMD;
        end else if (cmd_valid && op == OP_RUN && !active) begin
            state_n = ST_RUN;
            skip_n  = 1'b1;
        end else if (cmd_valid && op == OP_STEP && !active) begin
            state_n    = ST_STEP;
            skip_n     = 1'b1;
            step_rem_n = step_arg == '0 ? STEP_W'(1) : step_arg;
        end
        if (state_n != ST_STEP) step_rem_n = '0;
    end

    // controller state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= RUN_ON_RESET ? ST_RUN : ST_HALTED;
            cause    <= CAUSE_CMD;
            bp_en    <= 1'b0;
            bp_addr  <= '0;
            step_rem <= '0;
            skip     <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            state    <= state_n;
            cause    <= cause_n;
            bp_en    <= bp_en_n;
            bp_addr  <= bp_addr_n;
            step_rem <= step_rem_n;
            skip     <= skip_n;
            cmd_err  <= cmd_err_n;
        end
    end

    dbg_counter #(.W(CNT_W)) u_cycle (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .count (cycle_count)
    );

    dbg_counter #(.W(CNT_W)) u_retired (
        .clk   (clk),
        .reset (reset),
        .en    (core_en),
        .count (retired_count)
    );
endmodule
